// File: rtl/serial_crc5_parity_checker.sv
// Serial frame checker: accumulates running parity and CRC-5 per frame and
// emits a one-cycle result strobe with parity, CRC remainder, match and
// length-error flags at end of frame.
module serial_crc5_parity_checker #(
    parameter logic [4:0]  POLY     = 5'h05,
    parameter logic [4:0]  CRC_INIT = 5'h1F,
    parameter logic [4:0]  CHECK    = 5'h00,
    parameter int unsigned MAX_LEN  = 32,
    localparam int unsigned CW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bit_in,
    input  logic          bit_valid,
    input  logic          frame_start,
    input  logic          frame_end,
    output logic          in_ready,
    output logic          done,
    output logic          parity_out,
    output logic [4:0]    crc_out,
    output logic          crc_ok,
    output logic          len_err,
    output logic [CW-1:0] bit_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          done_q, done_d;
    logic          parity_q, parity_d;
    logic [4:0]    crc_q, crc_d;
    logic          crc_ok_q, crc_ok_d;
    logic          len_err_q, len_err_d;
    logic [CW-1:0] count_q, count_d;
    logic          accept;

    // One CRC-5 shift step with feedback XORed into the tap positions.
    function automatic logic [4:0] crc_step(input logic [4:0] c, input logic b);
        logic fb;
        fb = c[4] ^ b;
        return {c[3:0], 1'b0} ^ (fb ? POLY : 5'h00);
    endfunction

    assign accept = bit_valid & in_ready_q;

    // Next-state and result computation.
    always_comb begin
        state_d    = state_q;
        in_ready_d = 1'b1;
        done_d     = 1'b0;
        parity_d   = parity_q;
        crc_d      = crc_q;
        crc_ok_d   = crc_ok_q;
        len_err_d  = len_err_q;
        count_d    = count_q;

        case (state_q)
            IDLE, SHIFT: begin
                if (accept) begin
                    if (frame_start) begin
                        crc_d     = crc_step(CRC_INIT, bit_in);
                        parity_d  = bit_in;
                        count_d   = CW'(1);
                        crc_ok_d  = 1'b0;
                        len_err_d = 1'b0;
                    end else if (state_q == SHIFT) begin
                        crc_d    = crc_step(crc_q, bit_in);
                        parity_d = parity_q ^ bit_in;
                        if (count_q != CW'(MAX_LEN)) begin
                            count_d = count_q + CW'(1);
                        end
                    end
                    // Bits outside a frame are dropped; otherwise decide how the frame continues.
                    if (frame_start || (state_q == SHIFT)) begin
                        if (frame_end) begin
                            state_d = DONE;
                        end else if (count_d == CW'(MAX_LEN)) begin
                            len_err_d = 1'b1;
                            state_d   = DONE;
                        end else begin
                            state_d = SHIFT;
                        end
                    end
                end
                if (state_d == DONE) begin
                    done_d     = 1'b1;
                    in_ready_d = 1'b0;
                    crc_ok_d   = (crc_d == CHECK);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
            parity_q   <= 1'b0;
            crc_q      <= CRC_INIT;
            crc_ok_q   <= 1'b0;
            len_err_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            parity_q   <= parity_d;
            crc_q      <= crc_d;
            crc_ok_q   <= crc_ok_d;
            len_err_q  <= len_err_d;
            count_q    <= count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign done       = done_q;
    assign parity_out = parity_q;
    assign crc_out    = crc_q;
    assign crc_ok     = crc_ok_q;
    assign len_err    = len_err_q;
    assign bit_count  = count_q;

endmodule

// File: tb/tb_serial_crc5_parity_checker.sv
// Directed bench for serial_crc5_parity_checker: a default instance (MAX_LEN=32)
// and a MAX_LEN=4 instance sharing data/framing inputs with separate valids.
module tb_serial_crc5_parity_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       frame_start;
    logic       frame_end;
    logic       bv_a, bv_b;

    logic       in_ready_a, done_a, parity_a, crc_ok_a, len_err_a;
    logic [4:0] crc_a;
    logic [5:0] count_a;

    logic       in_ready_b, done_b, parity_b, crc_ok_b, len_err_b;
    logic [4:0] crc_b;
    logic [2:0] count_b;

    int checks = 0;
    int errors = 0;
    int dcnt_a = 0;
    int dcnt_b = 0;

    always #5 clk = ~clk;

    serial_crc5_parity_checker dut_a (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bv_a),
        .frame_start(frame_start), .frame_end(frame_end),
        .in_ready(in_ready_a), .done(done_a), .parity_out(parity_a),
        .crc_out(crc_a), .crc_ok(crc_ok_a), .len_err(len_err_a),
        .bit_count(count_a)
    );

    serial_crc5_parity_checker #(.MAX_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bv_b),
        .frame_start(frame_start), .frame_end(frame_end),
        .in_ready(in_ready_b), .done(done_b), .parity_out(parity_b),
        .crc_out(crc_b), .crc_ok(crc_ok_b), .len_err(len_err_b),
        .bit_count(count_b)
    );

    // Count done pulses mid-cycle so every strobe is seen once.
    always @(negedge clk) begin
        if (done_a === 1'b1) dcnt_a <= dcnt_a + 1;
        if (done_b === 1'b1) dcnt_b <= dcnt_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one bit to unit u (0 = default, 1 = MAX_LEN=4) until accepted.
    task automatic send_bit(input int u, input logic b, input logic s, input logic e,
                            output int cycles);
        logic acc;
        acc         = 1'b0;
        cycles      = 0;
        bit_in      = b;
        frame_start = s;
        frame_end   = e;
        bv_a        = (u == 0);
        bv_b        = (u == 1);
        for (int i = 0; i < 8 && !acc; i++) begin
            acc = (u == 0) ? (bv_a & in_ready_a) : (bv_b & in_ready_b);
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        bv_a        = 1'b0;
        bv_b        = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
    endtask

    int n;
    int d0;
    logic t3_bits [6];

    initial begin
        rst = 1'b1; bit_in = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
        bv_a = 1'b0; bv_b = 1'b0;
        tick(2);

        // Reset values
        check("rst_in_ready", 32'(in_ready_a), 32'd1);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_parity", 32'(parity_a), 32'd0);
        check("rst_crc", 32'(crc_a), 32'h1F);
        check("rst_crc_ok", 32'(crc_ok_a), 32'd0);
        check("rst_len_err", 32'(len_err_a), 32'd0);
        check("rst_count", 32'(count_a), 32'd0);
        rst = 1'b0;
        tick(1);

        // Test 1: one-bit frame
        send_bit(0, 1'b1, 1'b1, 1'b1, n);
        check("t1_done", 32'(done_a), 32'd1);
        check("t1_crc", 32'(crc_a), 32'h1E);
        check("t1_parity", 32'(parity_a), 32'd1);
        check("t1_count", 32'(count_a), 32'd1);
        check("t1_crc_ok", 32'(crc_ok_a), 32'd0);
        check("t1_len_err", 32'(len_err_a), 32'd0);
        check("t1_in_ready_done", 32'(in_ready_a), 32'd0);
        tick(1);
        check("t1_done_low", 32'(done_a), 32'd0);
        check("t1_in_ready_back", 32'(in_ready_a), 32'd1);
        check("t1_crc_hold", 32'(crc_a), 32'h1E);

        // Test 2: bits 1,0
        d0 = dcnt_a;
        send_bit(0, 1'b1, 1'b1, 1'b0, n);
        check("t2_mid_done", 32'(done_a), 32'd0);
        send_bit(0, 1'b0, 1'b0, 1'b1, n);
        check("t2_done", 32'(done_a), 32'd1);
        check("t2_crc", 32'(crc_a), 32'h19);
        check("t2_parity", 32'(parity_a), 32'd1);
        check("t2_count", 32'(count_a), 32'd2);
        tick(2);
        check("t2_pulses", 32'(dcnt_a - d0), 32'd1);

        // Test 3: data bit 1 followed by its CRC 11110
        t3_bits = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) send_bit(0, t3_bits[i], i == 0, i == 5, n);
        check("t3_done", 32'(done_a), 32'd1);
        check("t3_crc", 32'(crc_a), 32'h00);
        check("t3_crc_ok", 32'(crc_ok_a), 32'd1);
        check("t3_parity", 32'(parity_a), 32'd1);
        check("t3_count", 32'(count_a), 32'd6);
        tick(2);
        check("t3_crc_ok_hold", 32'(crc_ok_a), 32'd1);

        // Test 4: MAX_LEN=4 length error, then a bit held across the done cycle
        d0 = dcnt_b;
        send_bit(1, 1'b1, 1'b1, 1'b0, n);
        send_bit(1, 1'b0, 1'b0, 1'b0, n);
        send_bit(1, 1'b1, 1'b0, 1'b0, n);
        check("t4_no_early_done", 32'(done_b), 32'd0);
        send_bit(1, 1'b1, 1'b0, 1'b0, n);
        check("t4_done", 32'(done_b), 32'd1);
        check("t4_len_err", 32'(len_err_b), 32'd1);
        check("t4_count", 32'(count_b), 32'd4);
        check("t4_parity", 32'(parity_b), 32'd1);
        check("t4_in_ready", 32'(in_ready_b), 32'd0);
        send_bit(1, 1'b1, 1'b1, 1'b1, n);
        check("t4_held_cycles", 32'(n), 32'd2);
        check("t4_held_done", 32'(done_b), 32'd1);
        check("t4_held_crc", 32'(crc_b), 32'h1E);
        check("t4_held_len_err", 32'(len_err_b), 32'd0);
        check("t4_held_count", 32'(count_b), 32'd1);
        tick(2);
        check("t4_pulses", 32'(dcnt_b - d0), 32'd2);

        // Test 5: reset mid-frame
        d0 = dcnt_a;
        send_bit(0, 1'b1, 1'b1, 1'b0, n);
        send_bit(0, 1'b0, 1'b0, 1'b0, n);
        send_bit(0, 1'b1, 1'b0, 1'b0, n);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_rst_crc", 32'(crc_a), 32'h1F);
        check("t5_rst_count", 32'(count_a), 32'd0);
        check("t5_rst_parity", 32'(parity_a), 32'd0);
        check("t5_rst_in_ready", 32'(in_ready_a), 32'd1);
        tick(1);
        check("t5_no_done", 32'(dcnt_a - d0), 32'd0);
        send_bit(0, 1'b1, 1'b1, 1'b1, n);
        check("t5_done", 32'(done_a), 32'd1);
        check("t5_crc", 32'(crc_a), 32'h1E);
        check("t5_parity", 32'(parity_a), 32'd1);
        check("t5_count", 32'(count_a), 32'd1);
        check("t5_crc_ok", 32'(crc_ok_a), 32'd0);
        check("t5_len_err", 32'(len_err_a), 32'd0);
        tick(1);

        // Test 6: gaps hold state, then frame_start aborts and restarts
        d0 = dcnt_a;
        send_bit(0, 1'b1, 1'b1, 1'b0, n);
        tick(3);
        check("t6_gap1_crc", 32'(crc_a), 32'h1E);
        check("t6_gap1_count", 32'(count_a), 32'd1);
        check("t6_gap1_parity", 32'(parity_a), 32'd1);
        check("t6_gap1_done", 32'(done_a), 32'd0);
        send_bit(0, 1'b0, 1'b0, 1'b0, n);
        tick(3);
        check("t6_gap2_crc", 32'(crc_a), 32'h19);
        check("t6_gap2_count", 32'(count_a), 32'd2);
        send_bit(0, 1'b1, 1'b1, 1'b1, n);
        check("t6_done", 32'(done_a), 32'd1);
        check("t6_count", 32'(count_a), 32'd1);
        check("t6_crc", 32'(crc_a), 32'h1E);
        check("t6_parity", 32'(parity_a), 32'd1);
        tick(3);
        check("t6_pulses", 32'(dcnt_a - d0), 32'd1);
        check("t6_crc_hold", 32'(crc_a), 32'h1E);
        check("t6_count_hold", 32'(count_a), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_crc5_parity_checker.md
Name: serial_crc5_parity_checker

Overview:
Serial frame checker that sits directly downstream of the XOR gate library. It consumes a bit stream one bit per accepted cycle and accumulates two values per frame: a running parity, which is a chained 2-input XOR, and a CRC-5, which is a 5-bit shift register with XOR feedback taps. At end of frame it pulses a one-cycle result strobe with the parity, the CRC remainder, a CRC-match flag and a length-error flag. Link-level framing logic uses it to check incoming frames.

Parameters:
POLY, 5'h05, CRC feedback tap mask (x^5+x^2+1); bit k set means feedback is XORed into crc[k].
CRC_INIT, 5'h1F, CRC register value loaded for the first bit of each frame.
CHECK, 5'h00, final CRC value that counts as a good frame (data plus appended CRC, MSB first).
MAX_LEN, 32, maximum accepted bits per frame (at least 1); bit_count width is CW = clog2(MAX_LEN+1).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in is offered this cycle
frame_start  input  1  qualifies the offered bit as the first bit of a frame
frame_end  input  1  qualifies the offered bit as the last bit of a frame
in_ready  output  1  block can accept a bit this cycle
done  output  1  one-cycle result strobe
parity_out  output  1  XOR of all bits in the frame
crc_out  output  5  CRC register after the last bit
crc_ok  output  1  crc_out == CHECK
len_err  output  1  frame hit MAX_LEN bits without frame_end
bit_count  output  CW  bits accepted in the current or last frame

Behaviour:
- Clocking and reset: single clock domain. All state updates on the rising edge of clk.
- rst is sampled on the edge and has priority over everything.
- Reset values: state=IDLE, in_ready=1, done=0, parity_out=0, crc_out=CRC_INIT, crc_ok=0, len_err=0, bit_count=0.
- Handshake: a bit is accepted when bit_valid & in_ready.
  - in_ready=1 in IDLE and SHIFT, 0 in DONE.
  - A bit offered in DONE is not consumed; the source holds it.
- CRC step for an accepted bit b:
  - fb = crc[4] ^ b.
  - crc_next = {crc[3:0],1'b0} ^ (fb ? POLY : 5'h00).
- Parity step: p_next = p ^ b.
- Bit count: increments by 1 per accepted bit and never wraps.
- States:
  - IDLE: accepted bits without frame_start are dropped, with no state change. An accepted bit with frame_start loads crc=step(CRC_INIT,b), parity=b, bit_count=1 and clears crc_ok and len_err. Next state is DONE if frame_end is also set, else SHIFT.
  - SHIFT: each accepted bit updates crc, parity and bit_count.
    - frame_start on an accepted bit aborts the current frame and restarts as in IDLE. No done pulse is issued for the aborted frame.
    - frame_end on an accepted bit goes to DONE.
    - An accepted bit without frame_end that makes bit_count reach MAX_LEN sets len_err=1 and goes to DONE.
    - Cycles without an accepted bit hold all state.
  - DONE: lasts exactly one cycle, with done=1.
    - crc_ok is registered as (crc_out==CHECK) and is valid in the same cycle as done.
    - Next state is IDLE.
- Result hold: parity_out, crc_out, crc_ok, len_err and bit_count stay stable after DONE until the next accepted frame_start bit or rst.
- Latency: done asserts the cycle after the edge that accepted the last bit.
- Simultaneous frame_start and frame_end on one accepted bit is a one-bit frame.
- frame_start or frame_end with bit_valid=0 is ignored.
- When MAX_LEN=1, every accepted bit without frame_end ends its frame with len_err=1.
- Reset mid-frame: partial results are discarded, no done pulse is issued, and the block returns to the reset values on the next edge.

Test Plan:
1. Reset, then send one bit 1 with frame_start and frame_end -> next cycle done=1, crc_out=5'h1E, parity_out=1, bit_count=1, crc_ok=0, len_err=0.
2. Send bits 1,0 (start on the first, end on the second) -> crc_out=5'h19, parity_out=1, bit_count=2, one done pulse.
3. Send bits 1,1,1,1,1,0 (data 1 plus its CRC 11110) -> crc_out=5'h00, crc_ok=1, parity_out=1, bit_count=6.
4. With MAX_LEN=4, send four bits 1,0,1,1 with no frame_end -> done after the 4th bit, len_err=1, bit_count=4, parity_out=1. in_ready=0 during the done cycle, and a bit held valid then is accepted the next cycle.
5. Send 3 bits, assert rst for one cycle, then send a one-bit frame with bit 1 -> no done for the aborted frame; the result is identical to test 1.
6. Send 2 bits, then an accepted bit 1 with frame_start and frame_end -> single done pulse with bit_count=1, crc_out=5'h1E. Gaps with bit_valid=0 between bits leave the results unchanged.
